d_arb_merge: RTL and testbench
==============================

D_ARB_MERGE -- requirements
Module: d_arb_merge

Interface
REQ-001 SHALL have parameter Width, default 8, data width of all data ports.
REQ-002 SHALL have parameter CntWidth, default 16, width of per-source transfer counters.
REQ-003 SHALL have port clk_i  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port a_valid_i  input  1  source A data valid.
REQ-006 SHALL have port a_ready_o  output  1  source A accepted this cycle when high with a_valid_i.
REQ-007 SHALL have port a_data_i  input  Width  source A data.
REQ-008 SHALL have port b_valid_i  input  1  source B data valid.
REQ-009 SHALL have port b_ready_o  output  1  source B accepted this cycle when high with b_valid_i.
REQ-010 SHALL have port b_data_i  input  Width  source B data.
REQ-011 SHALL have port valid_o  output  1  merged output valid.
REQ-012 SHALL have port ready_i  input  1  downstream accepts value_o.
REQ-013 SHALL have port value_o  output  Width  merged data.
REQ-014 SHALL have port sel_o  output  1  source tag of value_o: 0 = A, 1 = B.
REQ-015 SHALL have port a_cnt_o  output  CntWidth  count of accepted A transfers.
REQ-016 SHALL have port b_cnt_o  output  CntWidth  count of accepted B transfers.

Function
REQ-017 SHALL hold one registered output entry; FSM states EMPTY (valid_o=0) and FULL (valid_o=1).
REQ-018 SHALL define can_load = (state==EMPTY) or (state==FULL and ready_i).
REQ-019 SHALL grant when can_load: only A valid -> A; only B valid -> B; both valid -> source opposite last_grant; neither -> none.
REQ-020 SHALL drive a_ready_o/b_ready_o high only for the granted source; never both high in one cycle.
REQ-021 SHALL update last_grant only on an input transfer (valid & ready), to the transferring source.
REQ-022 SHALL load value_o and sel_o on an input transfer; data visible with valid_o=1 the next cycle (latency 1).
REQ-023 Transitions: EMPTY -> FULL on input transfer; FULL -> EMPTY on ready_i with no input transfer; FULL -> FULL on ready_i with input transfer (back-to-back) or on !ready_i.
REQ-024 SHALL sustain one transfer per cycle while ready_i stays high and any source is valid.
REQ-025 SHALL hold value_o, sel_o, valid_o stable while valid_o=1 and ready_i=0.
REQ-026 SHALL increment a_cnt_o/b_cnt_o by 1 per accepted transfer of that source; wrap 2^CntWidth-1 -> 0.
REQ-027 SHALL ignore a_data_i/b_data_i when the corresponding valid is low.

Reset
REQ-028 SHALL, on a clock edge with rst_i=1: state=EMPTY, valid_o=0, value_o=0, sel_o=0, last_grant=B (A wins first tie), both counters 0.
REQ-029 SHALL force a_ready_o=b_ready_o=0 while rst_i=1, including reset asserted mid-operation; held output entry is discarded.

Structure
REQ-030 SHALL place state enum (ST_EMPTY, ST_FULL) and source enum (SRC_A=0, SRC_B=1) in shared package d_arb_pkg.
REQ-031 SHALL implement arbitration in sub-module rr_arb2 (2-requestor round-robin: combinational grant, last_grant register, update on accept).

Verification
REQ-032 Reset then A only: a_data_i=8'h11 valid 1 cycle, ready_i=1 -> next cycle valid_o=1, value_o=8'h11, sel_o=0, a_cnt_o=1.
REQ-033 Both valid continuously, A=8'hA0.., B=8'hB0.., ready_i=1 -> output A,B,A,B alternating, first A, one item per cycle.
REQ-034 Backpressure: output FULL with 8'h22, ready_i=0 for 5 cycles -> value_o stays 8'h22, a_ready_o=b_ready_o=0; release -> 8'h22 accepted once.
REQ-035 Counter wrap with CntWidth=4: 17 B transfers -> b_cnt_o=1, a_cnt_o=0.
REQ-036 Reset mid-stream while FULL and both valid -> next cycle valid_o=0, counters 0, readies 0; after release A wins first tie.

Source files
------------

// File: rtl/d_arb_pkg.sv
// Shared types for the two-source arbitrating merge: output-entry state and source tag.
package d_arb_pkg;
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;
  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-requestor round-robin arbiter: combinational grant, remembers the last accepted source.
module rr_arb2
  import d_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  src_e last_grant;

  // A grant is an accept: the requester is valid by construction, so |gnt is the transfer strobe.
  always_comb begin
    gnt = 2'b00;
    if (en && !rst_i) begin
      if (req[0] && req[1]) gnt = (last_grant == SRC_A) ? 2'b10 : 2'b01;
      else                  gnt = req;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)       last_grant <= SRC_B;
    else if (gnt[1]) last_grant <= SRC_B;
    else if (gnt[0]) last_grant <= SRC_A;
  end

endmodule

// File: rtl/d_arb_merge.sv
// Merges two valid/ready sources into one registered output entry with round-robin fairness.
module d_arb_merge
  import d_arb_pkg::*;
#(
  parameter int Width    = 8,
  parameter int CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                a_valid_i,
  output logic                a_ready_o,
  input  logic [Width-1:0]    a_data_i,
  input  logic                b_valid_i,
  output logic                b_ready_o,
  input  logic [Width-1:0]    b_data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [Width-1:0]    value_o,
  output logic                sel_o,
  output logic [CntWidth-1:0] a_cnt_o,
  output logic [CntWidth-1:0] b_cnt_o
);

  state_e     state;
  logic       can_load;
  logic [1:0] gnt;

  // Entry can be refilled in the same cycle it drains, giving full throughput.
  assign can_load = (state == ST_EMPTY) || ready_i;

  rr_arb2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (can_load),
    .req   ({b_valid_i, a_valid_i}),
    .gnt   (gnt)
  );

  assign a_ready_o = gnt[0];
  assign b_ready_o = gnt[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_EMPTY;
      valid_o <= 1'b0;
      value_o <= '0;
      sel_o   <= SRC_A;
      a_cnt_o <= '0;
      b_cnt_o <= '0;
    end else begin
      if (|gnt) begin
        state   <= ST_FULL;
        valid_o <= 1'b1;
        value_o <= gnt[1] ? b_data_i : a_data_i;
        sel_o   <= gnt[1] ? SRC_B : SRC_A;
      end else if (state == ST_FULL && ready_i) begin
        state   <= ST_EMPTY;
        valid_o <= 1'b0;
      end
      if (gnt[0]) a_cnt_o <= a_cnt_o + 1'b1;
      if (gnt[1]) b_cnt_o <= b_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_d_arb_merge.sv
// Randomized and directed bench for d_arb_merge against a transaction-level reference model.
module tb_d_arb_merge;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid, ready;
  logic [W-1:0]  a_data, b_data;
  logic          a_ready, b_ready, valid_o, sel_o;
  logic [W-1:0]  value_o;
  logic [CW-1:0] a_cnt, b_cnt;

  always #5 clk = ~clk;

  d_arb_merge #(.Width(W), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_data_i(a_data),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_data_i(b_data),
    .valid_o(valid_o), .ready_i(ready), .value_o(value_o), .sel_o(sel_o),
    .a_cnt_o(a_cnt), .b_cnt_o(b_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: one held item (or none), who won last, and transfer totals.
  bit         m_full;
  bit [W-1:0] m_val;
  bit         m_sel;
  bit         m_b_last;
  int         m_na, m_nb;
  bit         e_ga, e_gb;

  // Apply inputs just after an edge and work out who the spec says gets accepted.
  task automatic drive(input bit r, input bit av, input bit [W-1:0] ad,
                       input bit bv, input bit [W-1:0] bd, input bit rd);
    rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; ready = rd;
    e_ga = 0; e_gb = 0;
    if (!r && (!m_full || rd)) begin
      if (av && bv) begin
        if (m_b_last) e_ga = 1; else e_gb = 1;
      end else begin
        e_ga = av; e_gb = bv;
      end
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_val = 0; m_sel = 0; m_b_last = 1; m_na = 0; m_nb = 0;
    end else if (e_ga || e_gb) begin
      m_full = 1; m_sel = e_gb; m_val = e_gb ? b_data : a_data;
      m_b_last = e_gb;
      if (e_ga) m_na++; else m_nb++;
    end else if (ready) begin
      m_full = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    drive(1, 1, 8'h55, 1, 8'h66, 1);
    checks++;
    if ({a_ready, b_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got=%b exp=00", {a_ready, b_ready});
    end
    tick();
    checks++;
    if (valid_o !== 0 || value_o !== 0 || sel_o !== 0 || a_cnt !== 0 || b_cnt !== 0) begin
      errors++;
      $display("FAIL reset_state got v=%b val=%h s=%b ac=%0d bc=%0d exp all 0",
               valid_o, value_o, sel_o, a_cnt, b_cnt);
    end
  endtask

  task automatic test_a_only();
    do_reset();
    drive(0, 1, 8'h11, 0, 8'h99, 1);
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      errors++; $display("FAIL a_only_ready got=%b exp=10", {a_ready, b_ready});
    end
    tick();
    drive(0, 0, 0, 0, 0, 1);
    checks++;
    if (valid_o !== 1 || value_o !== 8'h11 || sel_o !== 0 || a_cnt !== 1 || b_cnt !== 0) begin
      errors++;
      $display("FAIL a_only_out got v=%b val=%h s=%b ac=%0d bc=%0d exp v=1 val=11 s=0 ac=1 bc=0",
               valid_o, value_o, sel_o, a_cnt, b_cnt);
    end
    tick();
    checks++;
    if (valid_o !== 0) begin
      errors++; $display("FAIL a_only_drain got v=%b exp=0", valid_o);
    end
  endtask

  task automatic test_alternate();
    int na = 0, nb = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 8'hA0 + W'(na), 1, 8'hB0 + W'(nb), 1);
      checks++;
      if ({b_ready, a_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL alt_ready[%0d] got ba=%b", i, {b_ready, a_ready});
      end
      if (a_ready) na++;
      if (b_ready) nb++;
      tick();
      checks++;
      if (valid_o !== 1 || sel_o !== bit'(i % 2) ||
          value_o !== ((i % 2 == 0) ? 8'hA0 + W'(i / 2) : 8'hB0 + W'(i / 2))) begin
        errors++;
        $display("FAIL alt_out[%0d] got v=%b s=%b val=%h exp s=%0d", i, valid_o, sel_o, value_o, i % 2);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(0, 1, 8'h22, 0, 0, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 8'h33, 1, 8'h44, 0);
      checks++;
      if ({a_ready, b_ready} !== 2'b00) begin
        errors++; $display("FAIL bp_ready[%0d] got=%b exp=00", i, {a_ready, b_ready});
      end
      tick();
      checks++;
      if (valid_o !== 1 || value_o !== 8'h22 || sel_o !== 0) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b val=%h exp v=1 val=22", i, valid_o, value_o);
      end
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
    checks++;
    if (valid_o !== 0 || a_cnt !== 1) begin
      errors++; $display("FAIL bp_release got v=%b ac=%0d exp v=0 ac=1", valid_o, a_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(0, 0, 0, 1, W'(i), 1);
      tick();
    end
    checks++;
    if (b_cnt !== 1 || a_cnt !== 0) begin
      errors++; $display("FAIL wrap got bc=%0d ac=%0d exp bc=1 ac=0", b_cnt, a_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(0, 1, 8'h01, 1, 8'h02, 1);
    tick();
    drive(0, 1, 8'h03, 1, 8'h04, 0);
    tick();
    drive(1, 1, 8'h05, 1, 8'h06, 1);
    checks++;
    if ({a_ready, b_ready} !== 2'b00) begin
      errors++; $display("FAIL mid_rst_ready got=%b exp=00", {a_ready, b_ready});
    end
    tick();
    checks++;
    if (valid_o !== 0 || a_cnt !== 0 || b_cnt !== 0) begin
      errors++; $display("FAIL mid_rst_state got v=%b ac=%0d bc=%0d exp 0", valid_o, a_cnt, b_cnt);
    end
    drive(0, 1, 8'h07, 1, 8'h08, 1);
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      errors++; $display("FAIL mid_rst_tie got=%b exp=10", {a_ready, b_ready});
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(0, 1'($urandom), W'($urandom), 1'($urandom), W'($urandom), ($urandom_range(0, 3) != 0));
      checks++;
      if (a_ready !== e_ga || b_ready !== e_gb) begin
        errors++; $display("FAIL rnd_ready[%0d] got=%b%b exp=%b%b", i, a_ready, b_ready, e_ga, e_gb);
      end
      tick();
      checks++;
      if (valid_o !== m_full || (m_full && (value_o !== m_val || sel_o !== m_sel)) ||
          a_cnt !== CW'(m_na) || b_cnt !== CW'(m_nb)) begin
        errors++;
        $display("FAIL rnd_out[%0d] got v=%b val=%h s=%b ac=%0d bc=%0d exp v=%b val=%h s=%b ac=%0d bc=%0d",
                 i, valid_o, value_o, sel_o, a_cnt, b_cnt, m_full, m_val, m_sel, CW'(m_na), CW'(m_nb));
      end
    end
  endtask

  initial begin
    rst = 1; a_valid = 0; b_valid = 0; a_data = 0; b_data = 0; ready = 0;
    m_full = 0; m_val = 0; m_sel = 0; m_b_last = 1; m_na = 0; m_nb = 0;
    @(posedge clk); #1;
    test_reset();
    test_a_only();
    test_alternate();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
